// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared state enum and latency/FIFO sizing for bram_rd_streamer.
// BRAM_RD_HIGH_PERF_EN selects LAT=2 (RAM output register used), else LAT=1.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

`ifdef BRAM_RD_HIGH_PERF_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int FIFO_DEPTH = LAT + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// bram_rd_skid_fifo: first-word-fall-through skid buffer, FIFO_DEPTH entries.
// Ports: clk, rstn, push/din in, pop in, dout (head), count, empty.
module bram_rd_skid_fifo
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: reads len_i words from base_addr_i over RAM port B and
// streams them valid/ready with backpressure. Ports: clk, rstn, start_i,
// base_addr_i, len_i, busy_o, done_o, mem_addrb_o, mem_enb_o,
// mem_oreg_enb_o, mem_doutb_i, m_data_o, m_valid_o, m_ready_i, m_last_o.
// Macro BRAM_RD_HIGH_PERF_EN: LAT=2 with RAM output register enable.
module bram_rd_streamer
  import bram_rd_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [AW-1:0]    base_addr_i,
  input  logic [AW:0]      len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW-1:0]    mem_addrb_o,
  output logic             mem_enb_o,
  output logic             mem_oreg_enb_o,
  input  logic [WIDTH-1:0] mem_doutb_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o
);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic [AW:0]   issue_cnt;
  logic [AW:0]   beat_cnt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;
  logic [LAT-1:0] cap_sr;
  logic          capture;
  logic          empty;
  logic          pop;
  logic          hs_last;
  logic          accept;

  assign accept   = (state == IDLE) && start_i && (len_i != '0);
  assign addr_nxt = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;

  assign m_valid_o = !empty;
  assign pop       = m_valid_o && m_ready_i;
  assign m_last_o  = m_valid_o && (beat_cnt == (AW+1)'(1));
  assign hs_last   = pop && (beat_cnt == (AW+1)'(1));

  assign mem_addrb_o = addr;
  assign capture     = cap_sr[LAT-1];

  // A beat leaving this cycle frees its slot before any new read can land,
  // which is what lets the stream sustain one beat per cycle.
  assign occ = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_enb_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i)
          state_n = (len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o    = 1'b1;
        mem_enb_o = (occ < (CW+1)'(FIFO_DEPTH));
        if (mem_enb_o && issue_cnt == (AW+1)'(1))
          state_n = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (hs_last)
          state_n = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr      <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      addr      <= base_addr_i;
      issue_cnt <= len_i;
      beat_cnt  <= len_i;
    end else begin
      if (mem_enb_o) begin
        addr      <= addr_nxt;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (pop)
        beat_cnt <= beat_cnt - 1'b1;
    end
  end

  // Capture strobe: the issue enable delayed by the RAM read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_sr   <= '0;
      inflight <= '0;
    end else begin
      cap_sr   <= LAT'({cap_sr, mem_enb_o});
      inflight <= inflight + CW'(mem_enb_o) - CW'(capture);
    end
  end

`ifdef BRAM_RD_HIGH_PERF_EN
  logic oreg_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      oreg_q <= 1'b0;
    else
      oreg_q <= mem_enb_o;
  end

  assign mem_oreg_enb_o = oreg_q;
`else
  assign mem_oreg_enb_o = 1'b0;
`endif

  bram_rd_skid_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (capture),
    .din   (mem_doutb_i),
    .pop   (pop),
    .dout  (m_data_o),
    .count (fifo_count),
    .empty (empty)
  );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb_bram_rd_streamer: directed table-driven bench for bram_rd_streamer
// with a behavioural RAM read port matching BRAM_RD_HIGH_PERF_EN.
module tb_bram_rd_streamer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
`ifdef BRAM_RD_HIGH_PERF_EN
  localparam int TB_LAT = 2;
`else
  localparam int TB_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start_i = 1'b0;
  logic [AW-1:0]    base_addr_i = '0;
  logic [AW:0]      len_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [AW-1:0]    mem_addrb_o;
  logic             mem_enb_o;
  logic             mem_oreg_enb_o;
  logic [WIDTH-1:0] mem_doutb_i = '0;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i = 1'b0;
  logic             m_last_o;

  int n_tests = 0;
  int n_fail  = 0;

  bram_rd_streamer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem_addrb_o    (mem_addrb_o),
    .mem_enb_o      (mem_enb_o),
    .mem_oreg_enb_o (mem_oreg_enb_o),
    .mem_doutb_i    (mem_doutb_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_last_o       (m_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int a);
    return 32'hDA7A_0000 + 32'(a);
  endfunction

`ifdef BRAM_RD_HIGH_PERF_EN
  logic [31:0] ram_s1 = '0;
  always @(posedge clk) begin
    if (mem_enb_o)
      ram_s1 <= word(int'(mem_addrb_o));
    if (mem_oreg_enb_o)
      mem_doutb_i <= ram_s1;
  end
`else
  always @(posedge clk) begin
    if (mem_enb_o)
      mem_doutb_i <= word(int'(mem_addrb_o));
  end
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_at(input int rmode, input int k);
    if (rmode == 0)
      return 1'b1;
    if (k >= 8 && k <= 17)
      return 1'b0;
    return (k % 2) == 1;
  endfunction

  typedef struct {
    int base;
    int len;
    int rmode;
    bit glitch;
    int exp_beats;
    int exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic run_xfer(input int base, input int len, input int rmode,
                          input bit glitch, input int exp_beats,
                          input int exp_last);
    int k, nb, first_k, last_k, done_k, budget;
    logic busy_at_done, prev_stall;
    logic [31:0] prev_data;
    k = 0; nb = 0; first_k = -1; last_k = -1; done_k = -1;
    busy_at_done = 1'b1; prev_stall = 1'b0; prev_data = '0;
    budget = 4 * len + 60;
    @(negedge clk);
    base_addr_i = AW'(base);
    len_i       = (AW+1)'(len);
    start_i     = 1'b1;
    m_ready_i   = ready_at(rmode, 0);
    while (done_k < 0 && k < budget) begin
      @(negedge clk);
      k++;
      start_i = glitch && (k == 3);
      if (glitch) begin
        base_addr_i = AW'(300);
        len_i       = (AW+1)'(5);
      end
      if (prev_stall)
        chk("stall_data_stable", 64'(m_data_o), 64'(prev_data));
      m_ready_i = ready_at(rmode, k);
      if (k == 1 && len > 0)
        chk("busy_after_start", 64'(busy_o), 64'(1));
      if (rmode == 1 && k == 17)
        chk("enb_low_in_hold", 64'(mem_enb_o), 64'(0));
      if (done_o) begin
        done_k       = k;
        busy_at_done = busy_o;
      end
      if (m_valid_o) begin
        if (nb == 0 && rmode == 0)
          chk("first_valid_lat", 64'(k), 64'(TB_LAT + 2));
        chk("last_flag", 64'(m_last_o), 64'(nb == len - 1));
        if (m_ready_i) begin
          chk("beat_data", 64'(m_data_o),
              64'(word((base + nb) % DEPTH)));
          if (nb == len - 1)
            chk("last_data", 64'(m_data_o), 64'(word(exp_last)));
          if (first_k < 0)
            first_k = k;
          last_k = k;
          nb++;
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
    end
    start_i   = 1'b0;
    m_ready_i = 1'b0;
    if (done_k < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", budget);
    end
    chk("beat_count", 64'(nb), 64'(exp_beats));
    if (len == 0)
      chk("done_after_zero_len", 64'(done_k), 64'(1));
    else
      chk("done_after_last", 64'(done_k), 64'(last_k + 1));
    if (rmode == 0 && len > 0)
      chk("back_to_back", 64'(last_k - first_k), 64'(len - 1));
    chk("busy_at_done", 64'(busy_at_done), 64'(0));
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_enb", 64'(mem_enb_o), 64'(0));
    chk("rst_oreg", 64'(mem_oreg_enb_o), 64'(0));
    chk("rst_addr", 64'(mem_addrb_o), 64'(0));
    chk("rst_valid", 64'(m_valid_o), 64'(0));
    chk("rst_last", 64'(m_last_o), 64'(0));
    chk("rst_data", 64'(m_data_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 5,   len: 4,   rmode: 0, glitch: 0,
                exp_beats: 4,   exp_last: 8};
    vecs[1] = '{base: 510, len: 4,   rmode: 0, glitch: 0,
                exp_beats: 4,   exp_last: 1};
    vecs[2] = '{base: 20,  len: 16,  rmode: 1, glitch: 0,
                exp_beats: 16,  exp_last: 35};
    vecs[3] = '{base: 7,   len: 0,   rmode: 0, glitch: 0,
                exp_beats: 0,   exp_last: 0};
    vecs[4] = '{base: 100, len: 8,   rmode: 0, glitch: 1,
                exp_beats: 8,   exp_last: 107};
    vecs[5] = '{base: 0,   len: 512, rmode: 0, glitch: 0,
                exp_beats: 512, exp_last: 511};
    vecs[6] = '{base: 511, len: 1,   rmode: 0, glitch: 0,
                exp_beats: 1,   exp_last: 511};

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].rmode,
               vecs[i].glitch, vecs[i].exp_beats, vecs[i].exp_last);

    @(negedge clk);
    base_addr_i = AW'(40);
    len_i       = (AW+1)'(32);
    start_i     = 1'b1;
    m_ready_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    m_ready_i = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_valid", 64'(m_valid_o), 64'(0));
    run_xfer(0, 2, 0, 1'b0, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
